// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Main control unit for a multicycle MIPS-style datapath. The FSM steps
// through FETCH, DECODE, then an instruction-class-specific execution path.
// It always returns to FETCH. Outputs are Moore functions of the state. Some
// outputs also depend on mem_ready, Zero, Op or Funct in selected states.
//
// Ports
//   clk          clock
//   reset        synchronous reset, active-high
//   Zero         ALU zero flag (branch decision)
//   mem_ready    memory access completes this cycle
//   Op, Funct    IR[31:26] and IR[5:0] of the instruction in IR
//   PCWrite      PC load enable
//   I_or_D       memory address select (1 = ALUOut)
//   Mem_Write    memory write strobe
//   IR_Write     IR load enable
//   PC_Src       00 ALU, 01 ALUOut, 10 jump target
//   Reg_Write    register file write
//   Mem_to_Reg   writeback select (1 = memory data)
//   Reg_Dst      destination select (1 = rd, 0 = rt)
//   ALUSrcA      0 = PC, 1 = A
//   ALUSrcB      00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   ALU_Control  010 add, 110 sub, 000 and, 001 or, 111 slt (upper bits 0)
//   illegal_op   one-cycle pulse on an undecodable Op or Funct
//   state_o      current state encoding
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int ALU_CTRL_W = 3,
    parameter bit ENABLE_BNE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Zero,
    input  logic                  mem_ready,
    input  logic [5:0]            Op,
    input  logic [5:0]            Funct,
    output logic                  PCWrite,
    output logic                  I_or_D,
    output logic                  Mem_Write,
    output logic                  IR_Write,
    output logic [1:0]            PC_Src,
    output logic                  Reg_Write,
    output logic                  Mem_to_Reg,
    output logic                  Reg_Dst,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALU_Control,
    output logic                  illegal_op,
    output logic [3:0]            state_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_reg;
    state_t     state_next;
    logic [2:0] alu_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        PCWrite    = 1'b0;
        I_or_D     = 1'b0;
        Mem_Write  = 1'b0;
        IR_Write   = 1'b0;
        PC_Src     = 2'b00;
        Reg_Write  = 1'b0;
        Mem_to_Reg = 1'b0;
        Reg_Dst    = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        alu_ctrl   = ALU_AND;
        illegal_op = 1'b0;

        case (state_reg)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                alu_ctrl = ALU_ADD;
                if (mem_ready) begin
                    IR_Write   = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB  = 2'b11;
                alu_ctrl = ALU_ADD;
                case (Op)
                    OP_RTYPE:       state_next = S_EXEC_R;
                    OP_LW, OP_SW:   state_next = S_MEM_ADR;
                    OP_ADDI, OP_ORI: state_next = S_EXEC_I;
                    OP_BEQ:         state_next = S_BRANCH;
                    OP_J:           state_next = S_JUMP;
                    OP_BNE: begin
                        if (ENABLE_BNE) begin
                            state_next = S_BRANCH;
                        end else begin
                            illegal_op = 1'b1;
                        end
                    end
                    default:        illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                alu_ctrl   = ALU_ADD;
                // Only lw and sw reach this state, so anything not sw is lw.
                state_next = (Op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                I_or_D     = 1'b1;
                state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                Reg_Write  = 1'b1;
                Mem_to_Reg = 1'b1;
            end
            S_MEM_WRITE: begin
                I_or_D     = 1'b1;
                Mem_Write  = 1'b1;
                state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                state_next = S_R_WB;
                case (Funct)
                    6'b100000: alu_ctrl = ALU_ADD;
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default: begin
                        // Unknown Funct: abandon the instruction, no writeback.
                        alu_ctrl   = ALU_ADD;
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_R_WB: begin
                Reg_Write = 1'b1;
                Reg_Dst   = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                alu_ctrl   = (Op == OP_ORI) ? ALU_OR : ALU_ADD;
                state_next = S_I_WB;
            end
            S_I_WB: begin
                Reg_Write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                alu_ctrl = ALU_SUB;
                PC_Src   = 2'b01;
                PCWrite  = (ENABLE_BNE && (Op == OP_BNE)) ? ~Zero : Zero;
            end
            S_JUMP: begin
                PC_Src  = 2'b10;
                PCWrite = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        // While reset is held the outputs present FETCH with no memory
        // completion, whatever state the register holds. This keeps a reset
        // landing mid-stall from leaking a write strobe or a writeback.
        if (reset) begin
            PCWrite    = 1'b0;
            I_or_D     = 1'b0;
            Mem_Write  = 1'b0;
            IR_Write   = 1'b0;
            PC_Src     = 2'b00;
            Reg_Write  = 1'b0;
            Mem_to_Reg = 1'b0;
            Reg_Dst    = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b01;
            alu_ctrl   = ALU_ADD;
            illegal_op = 1'b0;
        end
    end

    assign ALU_Control = ALU_CTRL_W'(alu_ctrl);
    assign state_o     = reset ? S_FETCH : state_reg;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_SLT = 4'b0111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] Op = '0;
    logic [5:0] Funct = '0;

    // Instance a: bne enabled, 4-bit ALU_Control (upper bit must stay 0).
    logic       a_pcw, a_iord, a_mw, a_irw, a_rw, a_m2r, a_rdst, a_srca, a_ill;
    logic [1:0] a_pcsrc, a_srcb;
    logic [3:0] a_alu, a_st;
    // Instance b: bne disabled, 3-bit ALU_Control.
    logic       b_pcw, b_iord, b_mw, b_irw, b_rw, b_m2r, b_rdst, b_srca, b_ill;
    logic [1:0] b_pcsrc, b_srcb;
    logic [2:0] b_alu;
    logic [3:0] b_st;

    multicycle_ctrl_fsm #(.ALU_CTRL_W(4), .ENABLE_BNE(1'b1)) dut (
        .clk(clk), .reset(reset), .Zero(Zero), .mem_ready(mem_ready),
        .Op(Op), .Funct(Funct), .PCWrite(a_pcw), .I_or_D(a_iord),
        .Mem_Write(a_mw), .IR_Write(a_irw), .PC_Src(a_pcsrc),
        .Reg_Write(a_rw), .Mem_to_Reg(a_m2r), .Reg_Dst(a_rdst),
        .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ALU_Control(a_alu),
        .illegal_op(a_ill), .state_o(a_st)
    );

    multicycle_ctrl_fsm #(.ALU_CTRL_W(3), .ENABLE_BNE(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .Zero(Zero), .mem_ready(mem_ready),
        .Op(Op), .Funct(Funct), .PCWrite(b_pcw), .I_or_D(b_iord),
        .Mem_Write(b_mw), .IR_Write(b_irw), .PC_Src(b_pcsrc),
        .Reg_Write(b_rw), .Mem_to_Reg(b_m2r), .Reg_Dst(b_rdst),
        .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ALU_Control(b_alu),
        .illegal_op(b_ill), .state_o(b_st)
    );

    // One cycle's worth of observable outputs.
    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       iord;
        logic       mw;
        logic       irw;
        logic [1:0] pcsrc;
        logic       rw;
        logic       m2r;
        logic       rdst;
        logic       srca;
        logic [1:0] srcb;
        logic [3:0] alu;
        logic       ill;
    } cyc_t;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        cyc_t       exp;
    } step_t;

    cyc_t obs_a, obs_b;
    assign obs_a = {a_st, a_pcw, a_iord, a_mw, a_irw, a_pcsrc, a_rw, a_m2r,
                    a_rdst, a_srca, a_srcb, a_alu, a_ill};
    assign obs_b = {b_st, b_pcw, b_iord, b_mw, b_irw, b_pcsrc, b_rw, b_m2r,
                    b_rdst, b_srca, b_srcb, {1'b0, b_alu}, b_ill};

    step_t      prog[$];
    cyc_t       obs[$];
    int         checks = 0;
    int         failures = 0;
    bit         sel_nb = 1'b0;
    logic [5:0] cur_op, cur_fn;
    logic       cur_z;

    // ---------------- reference model: per-instruction cycle traces ----------
    function automatic cyc_t mk(input logic [3:0] st);
        cyc_t c;
        c = '0;
        c.st = st;
        return c;
    endfunction

    function automatic cyc_t fetch_vals(input logic done);
        cyc_t c;
        c = mk(4'd0);
        c.srcb = 2'b01;
        c.alu = A_ADD;
        c.irw = done;
        c.pcw = done;
        return c;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic mr, input cyc_t e);
        step_t s;
        s.rst = 1'b0; s.mr = mr; s.op = cur_op; s.fn = cur_fn; s.z = cur_z; s.exp = e;
        prog.push_back(s);
    endtask

    task automatic push_rst(input logic mr);
        step_t s;
        s.rst = 1'b1; s.mr = mr; s.op = cur_op; s.fn = cur_fn; s.z = cur_z;
        s.exp = fetch_vals(1'b0);
        prog.push_back(s);
    endtask

    // Append the expected cycle trace of one complete instruction.
    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fstall, input int mstall, input bit bne_en);
        cyc_t c;
        bit   legal;
        cur_op = op; cur_fn = fn; cur_z = z;
        repeat (fstall) push(1'b0, fetch_vals(1'b0));
        push(1'b1, fetch_vals(1'b1));
        legal = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI) ||
                (op == OP_ORI) || (op == OP_BEQ) || (op == OP_J) || (op == OP_BNE && bne_en);
        c = mk(4'd1); c.srcb = 2'b11; c.alu = A_ADD; c.ill = !legal;
        push(rnd(), c);
        if (!legal) return;
        if (op == OP_LW || op == OP_SW) begin
            c = mk(4'd2); c.srca = 1'b1; c.srcb = 2'b10; c.alu = A_ADD;
            push(rnd(), c);
            c = (op == OP_LW) ? mk(4'd3) : mk(4'd5);
            c.iord = 1'b1; c.mw = (op == OP_SW);
            repeat (mstall) push(1'b0, c);
            push(1'b1, c);
            if (op == OP_LW) begin
                c = mk(4'd4); c.rw = 1'b1; c.m2r = 1'b1;
                push(rnd(), c);
            end
        end else if (op == OP_R) begin
            c = mk(4'd6); c.srca = 1'b1;
            case (fn)
                6'b100000: c.alu = A_ADD;
                6'b100010: c.alu = A_SUB;
                6'b100100: c.alu = A_AND;
                6'b100101: c.alu = A_OR;
                6'b101010: c.alu = A_SLT;
                default: begin c.alu = A_ADD; c.ill = 1'b1; end
            endcase
            push(rnd(), c);
            if (!c.ill) begin
                c = mk(4'd7); c.rw = 1'b1; c.rdst = 1'b1;
                push(rnd(), c);
            end
        end else if (op == OP_ADDI || op == OP_ORI) begin
            c = mk(4'd8); c.srca = 1'b1; c.srcb = 2'b10;
            c.alu = (op == OP_ORI) ? A_OR : A_ADD;
            push(rnd(), c);
            c = mk(4'd9); c.rw = 1'b1;
            push(rnd(), c);
        end else if (op == OP_BEQ || op == OP_BNE) begin
            c = mk(4'd10); c.srca = 1'b1; c.alu = A_SUB; c.pcsrc = 2'b01;
            c.pcw = (op == OP_BNE) ? ~z : z;
            push(rnd(), c);
        end else begin
            c = mk(4'd11); c.pcsrc = 2'b10; c.pcw = 1'b1;
            push(rnd(), c);
        end
    endtask

    // Drive each step at the falling edge and sample 1 ns later.
    task automatic run_prog();
        obs.delete();
        foreach (prog[i]) begin
            @(negedge clk);
            reset = prog[i].rst; mem_ready = prog[i].mr;
            Op = prog[i].op; Funct = prog[i].fn; Zero = prog[i].z;
            #1;
            obs.push_back(sel_nb ? obs_b : obs_a);
        end
    endtask

    // ---------------- scenarios -------------------------------------------
    task automatic test_reset();
        cur_op = OP_J; cur_fn = '0; cur_z = 1'b0;
        push_rst(1'b1);
        push_rst(1'b0);
        add_instr(OP_J, 6'd0, 1'b0, 0, 0, 1'b1);
        run_prog();
        foreach (prog[i]) begin
            checks++;
            if (obs[i] !== prog[i].exp) begin
                failures++;
                $display("FAIL reset cyc %0d: got %h want %h", i, obs[i], prog[i].exp);
            end
        end
        prog.delete();
    endtask

    task automatic test_lw();
        int wb_cycles;
        add_instr(OP_LW, 6'd0, 1'b0, 0, 0, 1'b1);
        run_prog();
        wb_cycles = 0;
        foreach (prog[i]) begin
            checks++;
            if (obs[i] !== prog[i].exp) begin
                failures++;
                $display("FAIL lw cyc %0d: got %h want %h", i, obs[i], prog[i].exp);
            end
            if (obs[i].rw && obs[i].m2r) wb_cycles++;
        end
        checks++;
        if (wb_cycles !== 1 || obs.size() !== 5) begin
            failures++;
            $display("FAIL lw_latency: got %0d cycles/%0d wb want 5/1", obs.size(), wb_cycles);
        end
        prog.delete();
    endtask

    task automatic test_sw_stall();
        int mw_cycles;
        int rw_cycles;
        add_instr(OP_SW, 6'd0, 1'b0, 0, 3, 1'b1);
        add_instr(OP_ADDI, 6'd0, 1'b0, 0, 0, 1'b1);
        run_prog();
        mw_cycles = 0;
        rw_cycles = 0;
        foreach (prog[i]) begin
            checks++;
            if (obs[i] !== prog[i].exp) begin
                failures++;
                $display("FAIL sw_stall cyc %0d: got %h want %h", i, obs[i], prog[i].exp);
            end
            if (i < 7 && obs[i].mw) mw_cycles++;
            if (i < 7 && obs[i].rw) rw_cycles++;
        end
        checks++;
        if (mw_cycles !== 4 || rw_cycles !== 0) begin
            failures++;
            $display("FAIL sw_counts: got mw=%0d rw=%0d want mw=4 rw=0", mw_cycles, rw_cycles);
        end
        prog.delete();
    endtask

    task automatic test_branch();
        add_instr(OP_BEQ, 6'd0, 1'b1, 0, 0, 1'b1);
        add_instr(OP_BEQ, 6'd0, 1'b0, 0, 0, 1'b1);
        add_instr(OP_BNE, 6'd0, 1'b1, 0, 0, 1'b1);
        add_instr(OP_BNE, 6'd0, 1'b0, 0, 0, 1'b1);
        run_prog();
        foreach (prog[i]) begin
            checks++;
            if (obs[i] !== prog[i].exp) begin
                failures++;
                $display("FAIL branch cyc %0d: got %h want %h", i, obs[i], prog[i].exp);
            end
        end
        prog.delete();
    endtask

    task automatic test_no_bne();
        sel_nb = 1'b1;
        push_rst(1'b1);
        add_instr(OP_BNE, 6'd0, 1'b0, 0, 0, 1'b0);
        add_instr(OP_BEQ, 6'd0, 1'b1, 0, 0, 1'b0);
        add_instr(OP_BNE, 6'd0, 1'b1, 1, 0, 1'b0);
        add_instr(OP_R, 6'b101010, 1'b0, 0, 0, 1'b0);
        push_rst(1'b0);
        run_prog();
        foreach (prog[i]) begin
            checks++;
            if (obs[i] !== prog[i].exp) begin
                failures++;
                $display("FAIL no_bne cyc %0d: got %h want %h", i, obs[i], prog[i].exp);
            end
        end
        prog.delete();
        sel_nb = 1'b0;
    endtask

    task automatic test_rtype();
        add_instr(OP_R, 6'b101010, 1'b0, 0, 0, 1'b1);
        add_instr(OP_R, 6'b111111, 1'b0, 0, 0, 1'b1);
        add_instr(OP_R, 6'b100010, 1'b0, 0, 0, 1'b1);
        add_instr(OP_ORI, 6'd0, 1'b0, 0, 0, 1'b1);
        run_prog();
        foreach (prog[i]) begin
            checks++;
            if (obs[i] !== prog[i].exp) begin
                failures++;
                $display("FAIL rtype cyc %0d: got %h want %h", i, obs[i], prog[i].exp);
            end
        end
        prog.delete();
    endtask

    task automatic test_fetch_stall();
        add_instr(OP_J, 6'd0, 1'b0, 2, 0, 1'b1);
        run_prog();
        foreach (prog[i]) begin
            checks++;
            if (obs[i] !== prog[i].exp) begin
                failures++;
                $display("FAIL fetch_stall cyc %0d: got %h want %h", i, obs[i], prog[i].exp);
            end
        end
        prog.delete();
    endtask

    task automatic test_reset_stall();
        // lw stalled in MEM_READ, reset on the third stall cycle.
        add_instr(OP_LW, 6'd0, 1'b0, 0, 3, 1'b1);
        repeat (3) void'(prog.pop_back());
        push_rst(1'b1);
        add_instr(OP_ADDI, 6'd0, 1'b0, 1, 0, 1'b1);
        // sw stalled in MEM_WRITE, reset during the stall.
        add_instr(OP_SW, 6'd0, 1'b0, 0, 2, 1'b1);
        repeat (2) void'(prog.pop_back());
        push_rst(1'b0);
        add_instr(OP_J, 6'd0, 1'b0, 0, 0, 1'b1);
        run_prog();
        foreach (prog[i]) begin
            checks++;
            if (obs[i] !== prog[i].exp) begin
                failures++;
                $display("FAIL reset_stall cyc %0d: got %h want %h", i, obs[i], prog[i].exp);
            end
        end
        prog.delete();
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [10];
        logic [5:0] fns [5];
        logic [5:0] op, fn;
        ops = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_BEQ, OP_BNE, OP_J, 6'h3f, 6'h00};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            fn = rnd() ? fns[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
            add_instr(op, fn, rnd(), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
        end
        run_prog();
        foreach (prog[i]) begin
            checks++;
            if (obs[i] !== prog[i].exp) begin
                failures++;
                $display("FAIL back_to_back cyc %0d op=%b fn=%b: got %h want %h",
                         i, prog[i].op, prog[i].fn, obs[i], prog[i].exp);
            end
        end
        prog.delete();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_branch();
        test_no_bne();
        test_rtype();
        test_fetch_stall();
        test_reset_stall();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
